ddr_in_frame_ctrl: RTL
======================

Name: ddr_in_frame_ctrl

Overview:
- Controller sitting directly behind the single-bit DDR input capture cell.
- Consumes the 2-bit-per-clock sample pair and deserializes it into WORD_W-bit words, MSB first.
- Hunts for a sync word at either bit phase (even/odd), verifies frame lock over several frames, then streams payload words with valid/start-of-frame strobes.
- Loss of sync returns it to hunting; used by serial front-end peripherals (e.g. ADC/link receivers).

Parameters:
- WORD_W, 16, word width in bits; must be even, >= 4.
- SYNC_PAT, 16'hA5C3, sync word occupying slot 0 of every frame (WORD_W bits).
- FRAME_LEN, 8, words per frame including the sync word; range 2..256.
- LOCK_CNT, 4, consecutive good sync words in VERIFY required to declare lock; >= 1.
- LOSS_CNT, 2, consecutive bad sync words in LOCK required to drop lock; >= 1.

Ports:
- clk_i  in  1  clock, same clock as the DDR capture cell.
- rst_n_i  in  1  reset; synchronous and active-low.
- en_i  in  1  enable; low forces HUNT, clears counters (shifting continues).
- ddr_i  in  2  capture pair: [0] = rising-edge sample (earlier bit), [1] = falling-edge sample.
- word_o  out  WORD_W  payload word.
- valid_o  out  1  single-cycle strobe; word_o is valid.
- sof_o  out  1  with valid_o, marks the first payload word (slot 1) of a frame.
- locked_o  out  1  high in LOCK state.
- odd_o  out  1  latched bit phase of the current alignment (1 = words end on ddr_i[0]).
- err_o  out  1  sticky; set on lock loss; cleared by reset or en_i low.

Behaviour:
- Reset (rst_n_i=0 at edge): state=HUNT; word_o=0; valid_o=0; sof_o=0; locked_o=0; odd_o=0; err_o=0; hist=0; all counters 0.
- Shift: every edge, hist (WORD_W+1 bits) <= {hist[WORD_W-2:0], ddr_i[0], ddr_i[1]}. Shifting is independent of en_i and state.
- Even candidate = hist[WORD_W-1:0]; odd candidate = hist[WORD_W:1]; selected candidate = odd_o ? odd : even.
- Phase counter ph counts 0..WORD_W/2-1. A word boundary occurs when ph==WORD_W/2-1. Slot counter sl counts 0..FRAME_LEN-1 and advances on each boundary.
- HUNT: each cycle compare the even candidate with SYNC_PAT, then the odd candidate. On match (even wins if both match): odd_o<=phase of the match, ph<=0, sl<=1, good<=1.
  - If LOCK_CNT==1, go to LOCK; else go to VERIFY.
- VERIFY: no output strobes. At a boundary with sl==0, compare the selected candidate with SYNC_PAT.
  - Match: good++; go to LOCK when good reaches LOCK_CNT.
  - Mismatch: go to HUNT.
- LOCK: locked_o=1. At a boundary with sl!=0, register word_o<=candidate and valid_o=1 for one cycle; sof_o=1 when sl==1.
  - At a boundary with sl==0, check sync: match clears miss; mismatch increments miss.
  - When miss reaches LOSS_CNT: go to HUNT, locked_o<=0, err_o<=1. The failing slot emits no strobe.
- Latency: valid_o/word_o are registered and appear 2 clocks after the edge sampling the ddr_i pair that carries the word's last bit.
- Boundary conditions:
  - Sync pattern appearing in payload during LOCK is ignored; alignment never moves while locked.
  - en_i low mid-frame: state=HUNT, valid_o/sof_o/locked_o=0 next cycle, err_o cleared, hist retained.
  - Reset mid-word discards the partial word.
  - sl wraps FRAME_LEN-1 -> 0; ph wraps WORD_W/2-1 -> 0.
  - Exactly one transition per cycle; LOCK->HUNT takes priority over any strobe in the same cycle.

Optional Feature:
- Macro DDR_IN_FRAME_CTRL_STATS_EN.
- When defined, adds outputs loss_cnt_o[15:0] and frame_cnt_o[15:0], both saturating counters.
  - loss_cnt_o increments on each LOCK->HUNT transition.
  - frame_cnt_o increments on each good sync check in LOCK.
  - Both clear on reset only (not on en_i).
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan (WORD_W=16, SYNC_PAT=A5C3, FRAME_LEN=4, LOCK_CNT=2, LOSS_CNT=2):
- Even-aligned stream of frames {A5C3,1111,2222,3333} repeated -> locked_o rises after 2nd sync; odd_o=0; next frame yields valid_o words 1111 (sof_o=1), 2222, 3333, each 2 clocks after its last pair.
- Same stream delayed by 1 bit -> odd_o=1, identical words/strobes.
- Locked, corrupt one sync to A5C2 -> no lock loss, err_o=0, words continue. Corrupt two consecutive syncs -> locked_o=0, err_o=1, no strobes until relock.
- Payload word A5C3 in slot 2 while locked -> emitted as data, alignment unchanged.
- en_i low for 1 cycle mid-frame -> valid_o/locked_o 0 next cycle, err_o cleared, relock after 2 syncs.
- rst_n_i low mid-word -> all outputs 0 next cycle. With DDR_IN_FRAME_CTRL_STATS_EN: 3 lock losses -> loss_cnt_o=3; frame_cnt_o saturates at FFFF.

Source files
------------

// File: rtl/ddr_in_frame_ctrl.sv
// DDR input frame controller: deserializes capture pairs, hunts sync, locks, streams payload.
// Optional statistics counters enabled by DDR_IN_FRAME_CTRL_STATS_EN.
module ddr_in_frame_ctrl #(
  parameter int unsigned       WORD_W    = 16,
  parameter logic [WORD_W-1:0] SYNC_PAT  = 16'hA5C3,
  parameter int unsigned       FRAME_LEN = 8,
  parameter int unsigned       LOCK_CNT  = 4,
  parameter int unsigned       LOSS_CNT  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [1:0]        ddr_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  output logic              sof_o,
  output logic              locked_o,
  output logic              odd_o,
  output logic              err_o
`ifdef DDR_IN_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]       loss_cnt_o,
  output logic [15:0]       frame_cnt_o
`endif
);

  localparam int unsigned HALF = WORD_W / 2;
  localparam int unsigned PH_W = $clog2(HALF);
  localparam int unsigned SL_W = $clog2(FRAME_LEN);
  localparam int unsigned GD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(LOSS_CNT + 1);

  localparam logic [PH_W-1:0] PH_MAX = PH_W'(HALF - 1);
  localparam logic [SL_W-1:0] SL_MAX = SL_W'(FRAME_LEN - 1);
  localparam logic [GD_W-1:0] GD_TGT = GD_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] MS_TGT = MS_W'(LOSS_CNT);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCK   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W:0]   hist_q, hist_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SL_W-1:0]   sl_q, sl_d;
  logic [GD_W-1:0]   good_q, good_d;
  logic [MS_W-1:0]   miss_q, miss_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              locked_q, locked_d;
  logic              odd_q, odd_d;
  logic              err_q, err_d;
  logic              lost, fgood;

  logic [WORD_W-1:0] even_c, odd_c, cand;
  logic              bnd, sync_ok;

  assign even_c  = hist_q[WORD_W-1:0];
  assign odd_c   = hist_q[WORD_W:1];
  assign cand    = odd_q ? odd_c : even_c;
  assign bnd     = (ph_q == PH_MAX);
  assign sync_ok = (cand == SYNC_PAT);
  assign hist_d  = {hist_q[WORD_W-2:0], ddr_i[0], ddr_i[1]};

  always_comb begin
    state_d = state_q;
    ph_d    = bnd ? '0 : ph_q + 1'b1;
    sl_d    = sl_q;
    if (bnd) sl_d = (sl_q == SL_MAX) ? '0 : sl_q + 1'b1;
    good_d  = good_q;
    miss_d  = miss_q;
    word_d  = word_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    odd_d   = odd_q;
    err_d   = err_q;
    lost    = 1'b0;
    fgood   = 1'b0;
    if (!en_i) begin
      state_d = S_HUNT;
      ph_d    = '0;
      sl_d    = '0;
      good_d  = '0;
      miss_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          // even phase wins when both phases match
          if (even_c == SYNC_PAT || odd_c == SYNC_PAT) begin
            odd_d   = (even_c != SYNC_PAT);
            ph_d    = '0;
            sl_d    = SL_W'(1);
            good_d  = GD_W'(1);
            miss_d  = '0;
            state_d = (LOCK_CNT == 1) ? S_LOCK : S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (bnd && sl_q == '0) begin
            if (sync_ok) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == GD_TGT) begin
                state_d = S_LOCK;
                miss_d  = '0;
              end
            end else begin
              state_d = S_HUNT;
            end
          end
        end
        S_LOCK: begin
          if (bnd) begin
            if (sl_q != '0) begin
              word_d  = cand;
              valid_d = 1'b1;
              sof_d   = (sl_q == SL_W'(1));
            end else if (sync_ok) begin
              miss_d = '0;
              fgood  = 1'b1;
            end else if (miss_q + 1'b1 == MS_TGT) begin
              state_d = S_HUNT;
              err_d   = 1'b1;
              lost    = 1'b1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_HUNT;
      hist_q   <= '0;
      ph_q     <= '0;
      sl_q     <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      locked_q <= 1'b0;
      odd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      ph_q     <= ph_d;
      sl_q     <= sl_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      locked_q <= locked_d;
      odd_q    <= odd_d;
      err_q    <= err_d;
    end
  end

  assign word_o   = word_q;
  assign valid_o  = valid_q;
  assign sof_o    = sof_q;
  assign locked_o = locked_q;
  assign odd_o    = odd_q;
  assign err_o    = err_q;

`ifdef DDR_IN_FRAME_CTRL_STATS_EN
  logic [15:0] loss_q, fcnt_q;

  // saturating; survive en_i low
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      loss_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (lost && loss_q != 16'hFFFF) loss_q <= loss_q + 1'b1;
      if (fgood && fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign loss_cnt_o  = loss_q;
  assign frame_cnt_o = fcnt_q;
`else
  logic unused_stats;
  assign unused_stats = lost | fgood;
`endif

endmodule
